mc_rf_resp: RTL and testbench
=============================

MC_RF_RESP -- requirements
Module: mc_rf_resp

Interface
REQ-001 SHALL have parameter NREG, default 64: number of 32-bit registers stored, legal range 2..64.
REQ-002 SHALL have ports:
  clk  input  1  sole clock, all state on rising edge.
  i_rst_n  input  1  asynchronous active-low reset.
  i_rf_rreq  input  1  read request pulse from core.
  i_rf_wreq  input  1  write request pulse from core.
  o_rf_ready  output  1  one-cycle acknowledge of a request.
  i_rreg0  input  6  read port 0 register index.
  i_rreg1  input  6  read port 1 register index.
  o_rdata0  output  1  read port 0 serial data, LSB first.
  o_rdata1  output  1  read port 1 serial data, LSB first.
  i_wreg0  input  6  write port 0 register index.
  i_wreg1  input  6  write port 1 register index.
  i_wen0  input  1  write port 0 bit enable.
  i_wen1  input  1  write port 1 bit enable.
  i_wdata0  input  1  write port 0 serial data, LSB first.
  i_wdata1  input  1  write port 1 serial data, LSB first.

Function
REQ-003 SHALL store NREG x 32 bits; indices >= NREG SHALL read 0 and discard writes.
REQ-004 Read FSM states: IDLE, ACK, STREAM; IDLE->ACK when i_rf_rreq sampled high (cycle T), latching i_rreg0/i_rreg1.
REQ-005 ACK: o_rf_ready=1 in cycle T+1 only; ACK->STREAM unconditionally.
REQ-006 STREAM: 5-bit counter; o_rdata0/o_rdata1 SHALL present bit k of latched registers in cycle T+2+k, k=0..31; after k=31 ->IDLE.
REQ-007 i_rf_rreq while in ACK or STREAM SHALL be ignored; no second ready.
REQ-008 i_rf_wreq sampled high SHALL latch i_wreg0/i_wreg1, clear both write bit counters, and cause o_rf_ready=1 next cycle.
REQ-009 i_rf_rreq and i_rf_wreq in same cycle SHALL produce exactly one o_rf_ready pulse serving both.
REQ-010 i_rf_wreq during a read stream SHALL be accepted and acknowledged without disturbing the stream.
REQ-011 Each cycle with i_wenN=1 SHALL write i_wdataN into bit counterN of latched wregN, then increment counterN; counter wraps 31->0.
REQ-012 Port 0 and port 1 writing same register and bit in same cycle: port 1 value SHALL win.
REQ-013 Read and write of same register bit in same cycle SHALL return the old value (read-before-write).
REQ-014 Outside STREAM o_rdata0/o_rdata1 SHALL be 0.

Reset
REQ-015 i_rst_n low SHALL immediately force o_rf_ready=0, o_rdata0=0, o_rdata1=0, read FSM to IDLE, all counters and latched indices to 0.
REQ-016 Reset SHALL clear all storage to 0, including mid-stream or mid-write; in-flight transfers are abandoned.
REQ-017 First request SHALL be accepted on the first rising edge after i_rst_n deasserts.

Configuration
REQ-018 Macro MC_RF_X0_ZERO_EN defined: index 0 SHALL read all zeros and discard writes.
REQ-019 Macro MC_RF_X0_ZERO_EN undefined: index 0 SHALL be ordinary storage.

Verification
REQ-020 Reset, rreq with rreg0=5, rreg1=6 -> ready at T+1, both rdata 0 for T+2..T+33.
REQ-021 wreq wreg0=3, 32 wen0 cycles writing 0xDEADBEEF LSB first; rreq rreg0=3 -> o_rdata0 streams 0xDEADBEEF from T+2.
REQ-022 rreq and wreq same cycle -> exactly one ready pulse; read of reg being written returns previous value 0x00000000.
REQ-023 Write 0x12345678 to reg 0 then read: with MC_RF_X0_ZERO_EN -> 0x00000000; without -> 0x12345678.
REQ-024 Assert i_rst_n low at read bit 10 of reg holding 0xFFFFFFFF -> rdata 0 at once; post-reset read returns 0x00000000.
REQ-025 NREG=32, write 0xA5A5A5A5 to index 40 then read index 40 -> 0x00000000; rreq during STREAM -> no extra ready.

Source files
------------

// File: rtl/mc_rf_resp.sv
// ============================================================================
// Module   : mc_rf_resp
// Purpose  : Bit-serial register file responder; macro MC_RF_X0_ZERO_EN
//            makes index 0 a hard-wired zero register.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mc_rf_resp #(
    parameter int NREG = 64
) (
    input  logic       clk,
    input  logic       i_rst_n,
    input  logic       i_rf_rreq,
    input  logic       i_rf_wreq,
    output logic       o_rf_ready,
    input  logic [5:0] i_rreg0,
    input  logic [5:0] i_rreg1,
    output logic       o_rdata0,
    output logic       o_rdata1,
    input  logic [5:0] i_wreg0,
    input  logic [5:0] i_wreg1,
    input  logic       i_wen0,
    input  logic       i_wen1,
    input  logic       i_wdata0,
    input  logic       i_wdata1
);

    localparam int         c_AW   = $clog2(NREG);
    localparam logic [6:0] c_NREG = 7'(NREG);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACK    = 2'd1,
        S_STREAM = 2'd2
    } state_t;

    state_t      state_q;
    logic        ready_q;
    logic [5:0]  rreg0_q;
    logic [5:0]  rreg1_q;
    logic [4:0]  rcnt_q;
    logic [5:0]  wreg0_q;
    logic [5:0]  wreg1_q;
    logic [4:0]  wcnt0_q;
    logic [4:0]  wcnt1_q;
    logic [31:0] rf_w [NREG];
    logic        w_bit0;
    logic        w_bit1;

    // Out-of-range write indices never match a stored register, so they drop.
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
        localparam logic [5:0] c_IDX = 6'(gi);
`ifdef MC_RF_X0_ZERO_EN
        localparam bit c_LOCK = (gi == 0);
`else
        localparam bit c_LOCK = 1'b0;
`endif
        logic [31:0] reg_q;
        logic        w_hit0;
        logic        w_hit1;

        assign w_hit0 = i_wen0 && (wreg0_q == c_IDX) && !c_LOCK;
        assign w_hit1 = i_wen1 && (wreg1_q == c_IDX) && !c_LOCK;

        // Port 1 is assigned last so it wins a same-bit collision.
        always_ff @(posedge clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                reg_q <= 32'd0;
            end else begin
                if (w_hit0) reg_q[wcnt0_q] <= i_wdata0;
                if (w_hit1) reg_q[wcnt1_q] <= i_wdata1;
            end
        end

        assign rf_w[gi] = reg_q;
    end

    always_comb begin
        w_bit0 = 1'b0;
        w_bit1 = 1'b0;
        if ({1'b0, rreg0_q} < c_NREG) w_bit0 = rf_w[rreg0_q[c_AW-1:0]][rcnt_q];
        if ({1'b0, rreg1_q} < c_NREG) w_bit1 = rf_w[rreg1_q[c_AW-1:0]][rcnt_q];
    end

    // Read data comes straight from stored state, so same-cycle writes are not seen.
    assign o_rdata0   = (state_q == S_STREAM) && w_bit0;
    assign o_rdata1   = (state_q == S_STREAM) && w_bit1;
    assign o_rf_ready = ready_q;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            rreg0_q <= 6'd0;
            rreg1_q <= 6'd0;
            rcnt_q  <= 5'd0;
        end else begin
            ready_q <= i_rf_wreq || ((state_q == S_IDLE) && i_rf_rreq);
            case (state_q)
                S_IDLE: begin
                    if (i_rf_rreq) begin
                        rreg0_q <= i_rreg0;
                        rreg1_q <= i_rreg1;
                        state_q <= S_ACK;
                    end
                end
                S_ACK: begin
                    rcnt_q  <= 5'd0;
                    state_q <= S_STREAM;
                end
                S_STREAM: begin
                    rcnt_q <= rcnt_q + 5'd1;
                    if (rcnt_q == 5'd31) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wreg0_q <= 6'd0;
            wreg1_q <= 6'd0;
            wcnt0_q <= 5'd0;
            wcnt1_q <= 5'd0;
        end else if (i_rf_wreq) begin
            wreg0_q <= i_wreg0;
            wreg1_q <= i_wreg1;
            wcnt0_q <= 5'd0;
            wcnt1_q <= 5'd0;
        end else begin
            if (i_wen0) wcnt0_q <= wcnt0_q + 5'd1;
            if (i_wen1) wcnt1_q <= wcnt1_q + 5'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mc_rf_resp.sv
// ============================================================================
// Module   : tb_mc_rf_resp
// Purpose  : Directed and random checks of mc_rf_resp (NREG=64 and NREG=32)
//            against a cycle-indexed reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mc_rf_resp;

`ifdef MC_RF_X0_ZERO_EN
    localparam bit c_X0 = 1'b1;
`else
    localparam bit c_X0 = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       i_rst_n = 1'b1;
    logic       i_rf_rreq = 1'b0, i_rf_wreq = 1'b0;
    logic [5:0] i_rreg0 = '0, i_rreg1 = '0, i_wreg0 = '0, i_wreg1 = '0;
    logic       i_wen0 = 1'b0, i_wen1 = 1'b0, i_wdata0 = 1'b0, i_wdata1 = 1'b0;
    logic       rdy64, r0_64, r1_64, rdy32, r0_32, r1_32;

    always #5 clk = ~clk;

    mc_rf_resp u_dut64 (
        .clk(clk), .i_rst_n(i_rst_n), .i_rf_rreq(i_rf_rreq), .i_rf_wreq(i_rf_wreq),
        .o_rf_ready(rdy64), .i_rreg0(i_rreg0), .i_rreg1(i_rreg1),
        .o_rdata0(r0_64), .o_rdata1(r1_64), .i_wreg0(i_wreg0), .i_wreg1(i_wreg1),
        .i_wen0(i_wen0), .i_wen1(i_wen1), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1)
    );

    mc_rf_resp #(.NREG(32)) u_dut32 (
        .clk(clk), .i_rst_n(i_rst_n), .i_rf_rreq(i_rf_rreq), .i_rf_wreq(i_rf_wreq),
        .o_rf_ready(rdy32), .i_rreg0(i_rreg0), .i_rreg1(i_rreg1),
        .o_rdata0(r0_32), .o_rdata1(r1_32), .i_wreg0(i_wreg0), .i_wreg1(i_wreg1),
        .i_wen0(i_wen0), .i_wen1(i_wen1), .i_wdata0(i_wdata0), .i_wdata1(i_wdata1)
    );

    // Reference model: register contents plus the cycle number of the accepted read.
    logic [31:0] m64 [64];
    logic [31:0] m32 [32];
    int          cyc = 0;
    int          rd_start = -1;
    int          rr0 = 0, rr1 = 0;
    int          mw0 = 0, mw1 = 0, mc0 = 0, mc1 = 0;
    logic        exp_ready = 1'b0;
    logic [31:0] cap0_64, cap1_64, cap0_32, cap1_32;
    int          rdy_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic mbit(input bit big, input int idx, input int k);
        if (big) return m64[idx][k];
        if (idx < 32) return m32[idx][k];
        return 1'b0;
    endfunction

    task automatic mwrite(input int idx, input int b, input logic d);
        if (!(c_X0 && idx == 0)) begin
            m64[idx][b] = d;
            if (idx < 32) m32[idx][b] = d;
        end
    endtask

    // One clock cycle: check outputs of the current cycle, then advance the model.
    task automatic tick();
        int   k;
        logic e0_64, e1_64, e0_32, e1_32, acc;
        #1;
        e0_64 = 1'b0; e1_64 = 1'b0; e0_32 = 1'b0; e1_32 = 1'b0;
        if (rd_start >= 0 && cyc >= rd_start + 2 && cyc <= rd_start + 33) begin
            k = cyc - rd_start - 2;
            e0_64 = mbit(1'b1, rr0, k);
            e1_64 = mbit(1'b1, rr1, k);
            e0_32 = mbit(1'b0, rr0, k);
            e1_32 = mbit(1'b0, rr1, k);
            cap0_64[k] = r0_64;
            cap1_64[k] = r1_64;
            cap0_32[k] = r0_32;
            cap1_32[k] = r1_32;
        end
        chk("ready64", 32'(rdy64), 32'(exp_ready));
        chk("ready32", 32'(rdy32), 32'(exp_ready));
        chk("rdata0_64", 32'(r0_64), 32'(e0_64));
        chk("rdata1_64", 32'(r1_64), 32'(e1_64));
        chk("rdata0_32", 32'(r0_32), 32'(e0_32));
        chk("rdata1_32", 32'(r1_32), 32'(e1_32));
        if (rdy64) rdy_cnt++;
        @(posedge clk);
        acc = i_rf_rreq && !(rd_start >= 0 && cyc <= rd_start + 33);
        exp_ready = acc || i_rf_wreq;
        if (acc) begin
            rd_start = cyc;
            rr0 = int'(i_rreg0);
            rr1 = int'(i_rreg1);
        end
        if (i_wen0) mwrite(mw0, mc0, i_wdata0);
        if (i_wen1) mwrite(mw1, mc1, i_wdata1);
        if (i_rf_wreq) begin
            mw0 = int'(i_wreg0); mw1 = int'(i_wreg1); mc0 = 0; mc1 = 0;
        end else begin
            if (i_wen0) mc0 = (mc0 + 1) % 32;
            if (i_wen1) mc1 = (mc1 + 1) % 32;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        #1;
        chk("rst_ready64", 32'(rdy64), 32'd0);
        chk("rst_ready32", 32'(rdy32), 32'd0);
        chk("rst_rdata0_64", 32'(r0_64), 32'd0);
        chk("rst_rdata1_64", 32'(r1_64), 32'd0);
        chk("rst_rdata0_32", 32'(r0_32), 32'd0);
        chk("rst_rdata1_32", 32'(r1_32), 32'd0);
        for (int i = 0; i < 64; i++) m64[i] = '0;
        for (int i = 0; i < 32; i++) m32[i] = '0;
        i_rf_rreq = 0; i_rf_wreq = 0; i_wen0 = 0; i_wen1 = 0;
        i_wdata0 = 0; i_wdata1 = 0;
        @(posedge clk);
        @(negedge clk);
        i_rst_n = 1'b1;
        rd_start = -1; exp_ready = 1'b0;
        mw0 = 0; mw1 = 0; mc0 = 0; mc1 = 0;
    endtask

    task automatic write_word(input int port, input int idx, input logic [31:0] data);
        i_wreg0 = 6'(idx);
        i_wreg1 = 6'(idx);
        i_rf_wreq = 1'b1;
        tick();
        i_rf_wreq = 1'b0;
        for (int b = 0; b < 32; b++) begin
            if (port == 0) begin i_wen0 = 1'b1; i_wdata0 = data[b]; end
            else           begin i_wen1 = 1'b1; i_wdata1 = data[b]; end
            tick();
        end
        i_wen0 = 1'b0; i_wen1 = 1'b0;
    endtask

    task automatic read_word(input int r0, input int r1, input bit inj_r, input bit inj_w);
        i_rreg0 = 6'(r0);
        i_rreg1 = 6'(r1);
        cap0_64 = '0; cap1_64 = '0; cap0_32 = '0; cap1_32 = '0;
        rdy_cnt = 0;
        i_rf_rreq = 1'b1;
        tick();
        i_rf_rreq = 1'b0;
        for (int t = 1; t <= 34; t++) begin
            if (inj_r && t == 10) i_rf_rreq = 1'b1;
            if (inj_w && t == 20) i_rf_wreq = 1'b1;
            tick();
            i_rf_rreq = 1'b0;
            i_rf_wreq = 1'b0;
        end
        chk("ready_count", 32'(rdy_cnt), 32'(1 + int'(inj_w)));
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Fresh registers read as zero.
        read_word(5, 6, 1'b0, 1'b0);
        chk("zero_r5", cap0_64, 32'h0000_0000);
        chk("zero_r6", cap1_64, 32'h0000_0000);

        write_word(0, 3, 32'hDEAD_BEEF);
        read_word(3, 0, 1'b0, 1'b0);
        chk("beef_64", cap0_64, 32'hDEAD_BEEF);
        chk("beef_32", cap0_32, 32'hDEAD_BEEF);

        // Simultaneous read+write request; writes land on the bit being streamed.
        i_rreg0 = 6'd7; i_rreg1 = 6'd7; i_wreg0 = 6'd7; i_wreg1 = 6'd7;
        cap0_64 = '0; cap1_64 = '0; rdy_cnt = 0;
        i_rf_rreq = 1'b1; i_rf_wreq = 1'b1;
        tick();
        i_rf_rreq = 1'b0; i_rf_wreq = 1'b0;
        tick();
        for (int b = 0; b < 32; b++) begin
            i_wen0 = 1'b1; i_wdata0 = 1'b1;
            tick();
        end
        i_wen0 = 1'b0;
        tick();
        chk("one_ready", 32'(rdy_cnt), 32'd1);
        chk("rbw_old", cap0_64, 32'h0000_0000);
        read_word(7, 7, 1'b0, 1'b0);
        chk("rbw_new0", cap0_64, 32'hFFFF_FFFF);
        chk("rbw_new1", cap1_64, 32'hFFFF_FFFF);

        write_word(0, 0, 32'h1234_5678);
        read_word(0, 3, 1'b0, 1'b0);
        chk("x0_read", cap0_64, c_X0 ? 32'h0000_0000 : 32'h1234_5678);
        chk("x0_other", cap1_64, 32'hDEAD_BEEF);

        // Both ports hammer the same register and bits; port 1 data must survive.
        i_wreg0 = 6'd9; i_wreg1 = 6'd9;
        i_rf_wreq = 1'b1;
        tick();
        i_rf_wreq = 1'b0;
        for (int b = 0; b < 32; b++) begin
            automatic logic [31:0] d0 = 32'h0F0F_1234;
            automatic logic [31:0] d1 = 32'h3C3C_5678;
            i_wen0 = 1'b1; i_wdata0 = d0[b];
            i_wen1 = 1'b1; i_wdata1 = d1[b];
            tick();
        end
        i_wen0 = 1'b0; i_wen1 = 1'b0;
        read_word(9, 3, 1'b0, 1'b0);
        chk("port1_wins", cap0_64, 32'h3C3C_5678);

        // Index 40 exists only in the 64-entry instance; extra rreq/wreq mid-stream.
        write_word(1, 40, 32'hA5A5_A5A5);
        i_wreg0 = 6'd1; i_wreg1 = 6'd1;
        read_word(40, 9, 1'b1, 1'b1);
        chk("idx40_64", cap0_64, 32'hA5A5_A5A5);
        chk("idx40_32", cap0_32, 32'h0000_0000);
        chk("idx9_32", cap1_32, 32'h3C3C_5678);

        // Reset in the middle of a stream of all-ones.
        write_word(0, 2, 32'hFFFF_FFFF);
        i_rreg0 = 6'd2; i_rreg1 = 6'd2;
        cap0_64 = '0;
        i_rf_rreq = 1'b1;
        tick();
        i_rf_rreq = 1'b0;
        for (int t = 0; t < 11; t++) tick();
        chk("pre_rst_bits", cap0_64 & 32'h0000_03FF, 32'h0000_03FF);
        do_reset();
        read_word(2, 3, 1'b0, 1'b0);
        chk("post_rst_r2", cap0_64, 32'h0000_0000);
        chk("post_rst_r3", cap1_64, 32'h0000_0000);

        for (int n = 0; n < 1500; n++) begin
            i_rf_rreq = ($urandom_range(0, 15) == 0);
            i_rf_wreq = ($urandom_range(0, 19) == 0);
            i_rreg0   = 6'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 63));
            i_rreg1   = 6'($urandom_range(0, 63));
            i_wreg0   = 6'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 63));
            i_wreg1   = 6'($urandom_range(0, 63));
            i_wen0    = i_rf_wreq ? 1'b0 : 1'($urandom_range(0, 1));
            i_wen1    = i_rf_wreq ? 1'b0 : 1'($urandom_range(0, 1));
            i_wdata0  = 1'($urandom_range(0, 1));
            i_wdata1  = 1'($urandom_range(0, 1));
            tick();
        end
        i_rf_rreq = 0; i_rf_wreq = 0; i_wen0 = 0; i_wen1 = 0;
        for (int n = 0; n < 40; n++) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
